// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ctrl
// Brief    : Pong paddle sequencer - button sync, move-rate tick, IDLE/PLAY/FREEZE
//            FSM. Optional AI tracking via macro PADDLE_AI_TRACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
    parameter int TICK_DIV     = 32768,
    parameter int Y_INIT       = 240,
    parameter int Y_MIN        = 20,
    parameter int Y_MAX        = 460,
    parameter int STEP         = 1,
    parameter int FREEZE_TICKS = 64,
    parameter int DEAD         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       game_run,
    input  logic       point_scored,
    input  logic       ai_sel,
    input  logic [9:0] ball_y,
    output logic [9:0] y_pos,
    output logic       tick,
    output logic       moved,
    output logic [1:0] state
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_FRZ_W = $clog2(FREEZE_TICKS + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_FRZ_W-1:0] c_FRZ_LOAD   = c_FRZ_W'(FREEZE_TICKS);
    localparam logic [c_FRZ_W-1:0] c_FRZ_ONE    = c_FRZ_W'(1);
    localparam logic [9:0]         c_Y_INIT     = 10'(Y_INIT);
    localparam logic [9:0]         c_STEP10     = 10'(STEP);
    localparam logic [10:0]        c_STEP11     = 11'(STEP);
    localparam logic [10:0]        c_Y_MAX11    = 11'(Y_MAX);
    localparam logic [10:0]        c_Y_MIN_STEP = 11'(Y_MIN + STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_FREEZE = 2'b10
    } state_t;

    state_t               state_q;
    logic [9:0]           y_pos_q;
    logic                 moved_q;
    logic [c_FRZ_W-1:0]   frz_cnt_q;
    logic [c_CNT_W-1:0]   tick_cnt_q;
    logic [c_CNT_W-1:0]   tick_cnt_d;
    logic [1:0]           up_sync_q;
    logic [1:0]           dn_sync_q;
    logic                 tick_w;
    logic                 up_req;
    logic                 down_req;
    logic                 can_down;
    logic                 can_up;
    logic [10:0]          y11;

    // Synchronisers idle at 1 so a released button never looks pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_sync_q <= 2'b11;
            dn_sync_q <= 2'b11;
        end else begin
            up_sync_q <= {up_sync_q[0], btn_up_n};
            dn_sync_q <= {dn_sync_q[0], btn_down_n};
        end
    end

    assign tick_w     = (tick_cnt_q == c_CNT_LAST);
    assign tick_cnt_d = tick_w ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end

    assign y11 = {1'b0, y_pos_q};

`ifdef PADDLE_AI_TRACK_EN
    logic [10:0] ball11;
    assign ball11   = {1'b0, ball_y};
    assign down_req = ai_sel ? (ball11 > y11 + 11'(DEAD)) : ~dn_sync_q[1];
    assign up_req   = ai_sel ? (ball11 + 11'(DEAD) < y11) : ~up_sync_q[1];
`else
    logic unused_ai;
    assign unused_ai = ^{ai_sel, ball_y};
    assign down_req  = ~dn_sync_q[1];
    assign up_req    = ~up_sync_q[1];
`endif

    // Out-of-range steps are dropped whole rather than clamped.
    assign can_down = down_req & ~up_req & ((y11 + c_STEP11) <= c_Y_MAX11);
    assign can_up   = up_req & ~down_req & (y11 >= c_Y_MIN_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            y_pos_q   <= c_Y_INIT;
            moved_q   <= 1'b0;
            frz_cnt_q <= '0;
        end else begin
            moved_q <= 1'b0;
            if (!game_run) begin
                state_q   <= ST_IDLE;
                y_pos_q   <= c_Y_INIT;
                frz_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_PLAY;
                    ST_PLAY: begin
                        if (point_scored) begin
                            state_q   <= ST_FREEZE;
                            frz_cnt_q <= c_FRZ_LOAD;
                        end else if (tick_w) begin
                            if (can_down) begin
                                y_pos_q <= y_pos_q + c_STEP10;
                                moved_q <= 1'b1;
                            end else if (can_up) begin
                                y_pos_q <= y_pos_q - c_STEP10;
                                moved_q <= 1'b1;
                            end
                        end
                    end
                    ST_FREEZE: begin
                        if (tick_w) begin
                            if (frz_cnt_q == c_FRZ_ONE) begin
                                frz_cnt_q <= '0;
                                y_pos_q   <= c_Y_INIT;
                                state_q   <= ST_PLAY;
                            end else begin
                                frz_cnt_q <= frz_cnt_q - 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign y_pos = y_pos_q;
    assign tick  = tick_w;
    assign moved = moved_q;
    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_ctrl
// Brief    : Directed self-checking bench for paddle_ctrl (TICK_DIV=4, FREEZE_TICKS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_up_n;
    logic       btn_down_n;
    logic       game_run;
    logic       point_scored;
    logic       ai_sel;
    logic [9:0] ball_y;
    logic [9:0] y_pos;
    logic       tick;
    logic       moved;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int mcnt;

    paddle_ctrl #(
        .TICK_DIV     (4),
        .Y_INIT       (240),
        .Y_MIN        (20),
        .Y_MAX        (460),
        .STEP         (1),
        .FREEZE_TICKS (3),
        .DEAD         (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up_n     (btn_up_n),
        .btn_down_n   (btn_down_n),
        .game_run     (game_run),
        .point_scored (point_scored),
        .ai_sel       (ai_sel),
        .ball_y       (ball_y),
        .y_pos        (y_pos),
        .tick         (tick),
        .moved        (moved),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic count_moves(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (moved) cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; btn_up_n = 1'b1; btn_down_n = 1'b1; game_run = 1'b0;
        point_scored = 1'b0; ai_sel = 1'b0; ball_y = 10'd0;
        step(2);
        check_val("rst_y", y_pos, 240);
        check_val("rst_state", state, 0);
        check_val("rst_tick", tick, 0);
        check_val("rst_moved", moved, 0);

        // Release, run down; counter phase n after the n-th released edge
        rst = 1'b0; game_run = 1'b1; btn_down_n = 1'b0;
        step(2);
        check_val("play_state", state, 1);
        check_val("tick_c2", tick, 0);
        step(1);
        check_val("tick_c3", tick, 1);
        step(1);
        check_val("first_move_y", y_pos, 241);
        check_val("first_move_pulse", moved, 1);
        check_val("tick_wrap", tick, 0);
        step(1);
        check_val("moved_one_cycle", moved, 0);
        step(35);
        check_val("run40_y", y_pos, 250);
        check_val("run40_moved", moved, 1);

        // Point coincident with tick
        step(3);
        check_val("pt_tick", tick, 1);
        point_scored = 1'b1; btn_down_n = 1'b1;
        step(1);
        point_scored = 1'b0;
        check_val("frz_state", state, 2);
        check_val("frz_nomove_y", y_pos, 250);
        check_val("frz_nomove_pulse", moved, 0);
        step(7);
        point_scored = 1'b1;
        step(1);
        point_scored = 1'b0;
        check_val("frz_hold_state", state, 2);
        check_val("frz_hold_y", y_pos, 250);
        step(4);
        check_val("recentre_state", state, 1);
        check_val("recentre_y", y_pos, 240);
        check_val("recentre_moved", moved, 0);

        // Bottom boundary
        btn_down_n = 1'b0;
        step(980);
        check_val("bottom_y", y_pos, 460);
        count_moves(80, mcnt);
        check_val("bottom_moves", mcnt, 0);
        check_val("bottom_y_hold", y_pos, 460);

        // Top boundary
        btn_down_n = 1'b1; btn_up_n = 1'b0;
        step(1800);
        check_val("top_y", y_pos, 20);
        count_moves(80, mcnt);
        check_val("top_moves", mcnt, 0);
        check_val("top_y_hold", y_pos, 20);

        // game_run drop mid-PLAY, then both buttons held
        game_run = 1'b0; btn_down_n = 1'b0;
        step(1);
        check_val("drop_play_state", state, 0);
        check_val("drop_play_y", y_pos, 240);
        check_val("drop_play_moved", moved, 0);
        game_run = 1'b1;
        step(1);
        check_val("rerun_state", state, 1);
        count_moves(40, mcnt);
        check_val("both_moves", mcnt, 0);
        check_val("both_y", y_pos, 240);

        // game_run drop mid-FREEZE
        btn_up_n = 1'b1;
        step(40);
        point_scored = 1'b1;
        step(1);
        point_scored = 1'b0;
        check_val("frz2_state", state, 2);
        step(2);
        game_run = 1'b0;
        step(1);
        check_val("drop_frz_state", state, 0);
        check_val("drop_frz_y", y_pos, 240);
        game_run = 1'b1; btn_down_n = 1'b1;
        step(1);
        check_val("drop_frz_rerun", state, 1);

        // rst mid-PLAY
        btn_down_n = 1'b0;
        step(20);
        rst = 1'b1;
        step(1);
        check_val("mid_rst_y", y_pos, 240);
        check_val("mid_rst_state", state, 0);
        check_val("mid_rst_tick", tick, 0);
        check_val("mid_rst_moved", moved, 0);

`ifdef PADDLE_AI_TRACK_EN
        btn_down_n = 1'b1; ai_sel = 1'b1; ball_y = 10'd300;
        rst = 1'b0;
        step(400);
        check_val("ai_down_y", y_pos, 296);
        count_moves(40, mcnt);
        check_val("ai_down_moves", mcnt, 0);
        ball_y = 10'd100;
        step(800);
        check_val("ai_up_y", y_pos, 104);
`else
        btn_down_n = 1'b1; btn_up_n = 1'b0; ai_sel = 1'b1; ball_y = 10'd300;
        rst = 1'b0;
        step(40);
        check_val("noai_btn_y", y_pos, 230);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
